// File: rtl/segment_queue_if.sv
// Command/result bundle for segment_queue: the master issues commands, the slave returns
// registered results and occupancy flags.
interface segment_queue_if #(
    parameter int DEPTH = 16,
    parameter int POS_W = 8,
    parameter int DIR_W = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic             op_en;
    logic [2:0]       mode;
    logic [POS_W-1:0] wr_pos;
    logic [DIR_W-1:0] wr_dir;
    logic [AW-1:0]    address;
    logic [POS_W-1:0] updated_pos;
    logic [DIR_W-1:0] updated_dir;
    logic             out_valid;
    logic             err;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;

    modport master (
        output op_en, mode, wr_pos, wr_dir, address,
        input  updated_pos, updated_dir, out_valid, err, full, empty, count
    );

    modport slave (
        input  op_en, mode, wr_pos, wr_dir, address,
        output updated_pos, updated_dir, out_valid, err, full, empty, count
    );
endinterface

// File: rtl/segment_queue.sv
// Circular queue of {pos,dir} segments with push/pop/move plus indexed read/write.
// Index 0 is the newest entry; every result is registered one edge after the command.
module segment_queue #(
    parameter int DEPTH = 16,
    parameter int POS_W = 8,
    parameter int DIR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    segment_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_MOVE  = 3'b011;
    localparam logic [2:0] OP_READ  = 3'b100;
    localparam logic [2:0] OP_WRITE = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;

    logic [POS_W-1:0] pos_mem [DEPTH];
    logic [DIR_W-1:0] dir_mem [DEPTH];

    // head_q is the next free slot; the newest entry lives at head_q-1
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [POS_W-1:0] upd_pos_q, upd_pos_d;
    logic [DIR_W-1:0] upd_dir_q, upd_dir_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    idx_slot;
    logic             is_full, is_empty, addr_ok;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign addr_ok  = ({1'b0, bus.address} < count_q);
    assign idx_slot = head_q - AW'(1) - bus.address;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        upd_pos_d   = upd_pos_q;
        upd_dir_d   = upd_dir_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = head_q;
        if (bus.op_en) begin
            case (bus.mode)
                OP_NOP: ;
                OP_PUSH: begin
                    if (is_full) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we      = 1'b1;
                        head_d      = head_q + AW'(1);
                        count_d     = count_q + CW'(1);
                        upd_pos_d   = bus.wr_pos;
                        upd_dir_d   = bus.wr_dir;
                        out_valid_d = 1'b1;
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        err_d = 1'b1;
                    end else begin
                        tail_d      = tail_q + AW'(1);
                        count_d     = count_q - CW'(1);
                        upd_pos_d   = pos_mem[tail_q];
                        upd_dir_d   = dir_mem[tail_q];
                        out_valid_d = 1'b1;
                    end
                end
                OP_MOVE: begin
                    // when full, head and tail share a slot; the old tail is read before the write lands
                    mem_we      = 1'b1;
                    head_d      = head_q + AW'(1);
                    out_valid_d = 1'b1;
                    if (is_empty) begin
                        count_d   = count_q + CW'(1);
                        upd_pos_d = bus.wr_pos;
                        upd_dir_d = bus.wr_dir;
                    end else begin
                        tail_d    = tail_q + AW'(1);
                        upd_pos_d = pos_mem[tail_q];
                        upd_dir_d = dir_mem[tail_q];
                    end
                end
                OP_READ: begin
                    if (addr_ok) begin
                        upd_pos_d   = pos_mem[idx_slot];
                        upd_dir_d   = dir_mem[idx_slot];
                        out_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_WRITE: begin
                    if (addr_ok) begin
                        mem_we      = 1'b1;
                        mem_waddr   = idx_slot;
                        upd_pos_d   = bus.wr_pos;
                        upd_dir_d   = bus.wr_dir;
                        out_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            upd_pos_q   <= '0;
            upd_dir_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            upd_pos_q   <= upd_pos_d;
            upd_dir_q   <= upd_dir_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    // storage is not reset; occupancy alone decides which slots are meaningful
    always_ff @(posedge clk) begin
        if (mem_we) begin
            pos_mem[mem_waddr] <= bus.wr_pos;
            dir_mem[mem_waddr] <= bus.wr_dir;
        end
    end

    assign bus.updated_pos = upd_pos_q;
    assign bus.updated_dir = upd_dir_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.err         = err_q;
    assign bus.count       = count_q;
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
endmodule

// File: tb/tb_segment_queue.sv
// Directed bench for segment_queue (DEPTH=16) with hand-computed expectations and a
// small newest-first queue model for the long MOVE run.
module tb_segment_queue;
    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, MOVE = 3'd3;
    localparam logic [2:0] READ = 3'd4, WRITE = 3'd5, CLEAR = 3'd6, RSVD = 3'd7;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    segment_queue_if #(.DEPTH(16), .POS_W(8), .DIR_W(8)) bus ();

    segment_queue #(.DEPTH(16), .POS_W(8), .DIR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int m_pos[$];
    int m_dir[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] m, input logic [7:0] p, input logic [7:0] d,
                       input logic [3:0] a);
        @(negedge clk);
        bus.op_en   = 1'b1;
        bus.mode    = m;
        bus.wr_pos  = p;
        bus.wr_dir  = d;
        bus.address = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.op_en = 1'b0;
        bus.mode  = NOP;
    endtask

    initial begin
        int exp_p, exp_d;
        bus.op_en   = 1'b0;
        bus.mode    = NOP;
        bus.wr_pos  = '0;
        bus.wr_dir  = '0;
        bus.address = '0;
        #12;
        check("rst_count", int'(bus.count), 0);
        check("rst_empty", int'(bus.empty), 1);
        check("rst_full", int'(bus.full), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_pos", int'(bus.updated_pos), 0);
        check("rst_dir", int'(bus.updated_dir), 0);
        @(negedge clk);
        reset = 1'b1;

        cmd(POP, 8'h00, 8'h00, 4'd0);
        check("pop_empty_err", int'(bus.err), 1);
        check("pop_empty_valid", int'(bus.out_valid), 0);
        check("pop_empty_count", int'(bus.count), 0);
        check("pop_empty_empty", int'(bus.empty), 1);

        for (int i = 0; i < 16; i++) begin
            cmd(PUSH, 8'(i), 8'(8'h80 + i), 4'd0);
            check("push_valid", int'(bus.out_valid), 1);
            check("push_echo", int'(bus.updated_pos), i);
            m_pos.push_front(i);
            m_dir.push_front(8'h80 + i);
        end
        check("full_flag", int'(bus.full), 1);
        check("full_empty", int'(bus.empty), 0);
        check("full_count", int'(bus.count), 16);

        cmd(PUSH, 8'h77, 8'h77, 4'd0);
        check("push_full_err", int'(bus.err), 1);
        check("push_full_valid", int'(bus.out_valid), 0);
        check("push_full_count", int'(bus.count), 16);
        check("hold_pos", int'(bus.updated_pos), 15);

        cmd(READ, 8'h00, 8'h00, 4'd0);
        check("read0_pos", int'(bus.updated_pos), 15);
        check("read0_dir", int'(bus.updated_dir), 8'h8F);
        cmd(READ, 8'h00, 8'h00, 4'd15);
        check("read15_pos", int'(bus.updated_pos), 0);
        check("read15_valid", int'(bus.out_valid), 1);

        cmd(MOVE, 8'hAA, 8'h01, 4'd0);
        m_pos.push_front(8'hAA);
        m_dir.push_front(8'h01);
        void'(m_pos.pop_back());
        void'(m_dir.pop_back());
        check("move_full_valid", int'(bus.out_valid), 1);
        check("move_full_pos", int'(bus.updated_pos), 0);
        check("move_full_dir", int'(bus.updated_dir), 8'h80);
        check("move_full_count", int'(bus.count), 16);
        cmd(READ, 8'h00, 8'h00, 4'd0);
        check("move_read0", int'(bus.updated_pos), 8'hAA);

        for (int i = 0; i < 20; i++) begin
            cmd(MOVE, 8'(8'h30 + i), 8'(8'h40 + i), 4'd0);
            m_pos.push_front(8'h30 + i);
            m_dir.push_front(8'h40 + i);
            exp_p = m_pos.pop_back();
            exp_d = m_dir.pop_back();
            check("moveN_pos", int'(bus.updated_pos), exp_p);
            check("moveN_dir", int'(bus.updated_dir), exp_d);
        end
        check("moveN_count", int'(bus.count), 16);
        for (int a = 0; a < 16; a++) begin
            cmd(READ, 8'h00, 8'h00, 4'(a));
            check("wrap_read_pos", int'(bus.updated_pos), m_pos[a]);
            check("wrap_read_dir", int'(bus.updated_dir), m_dir[a]);
        end

        cmd(CLEAR, 8'h00, 8'h00, 4'd0);
        check("clear_count", int'(bus.count), 0);
        check("clear_err", int'(bus.err), 0);
        check("clear_valid", int'(bus.out_valid), 0);
        check("clear_empty", int'(bus.empty), 1);

        cmd(PUSH, 8'h01, 8'h11, 4'd0);
        cmd(PUSH, 8'h02, 8'h12, 4'd0);
        cmd(PUSH, 8'h03, 8'h13, 4'd0);
        cmd(READ, 8'h00, 8'h00, 4'd3);
        check("read_oob_err", int'(bus.err), 1);
        check("read_oob_valid", int'(bus.out_valid), 0);
        cmd(WRITE, 8'h66, 8'h66, 4'd3);
        check("write_oob_err", int'(bus.err), 1);
        cmd(READ, 8'h00, 8'h00, 4'd2);
        check("read_tail", int'(bus.updated_pos), 8'h01);
        cmd(WRITE, 8'h55, 8'h02, 4'd1);
        check("write_valid", int'(bus.out_valid), 1);
        check("write_echo_pos", int'(bus.updated_pos), 8'h55);
        check("write_echo_dir", int'(bus.updated_dir), 8'h02);
        check("write_count", int'(bus.count), 3);
        cmd(READ, 8'h00, 8'h00, 4'd0);
        check("write_neighbour", int'(bus.updated_pos), 8'h03);
        cmd(READ, 8'h00, 8'h00, 4'd1);
        check("write_read_pos", int'(bus.updated_pos), 8'h55);
        check("write_read_dir", int'(bus.updated_dir), 8'h02);

        cmd(RSVD, 8'h00, 8'h00, 4'd0);
        check("rsvd_err", int'(bus.err), 1);
        check("rsvd_count", int'(bus.count), 3);
        cmd(NOP, 8'h00, 8'h00, 4'd0);
        check("nop_err", int'(bus.err), 0);
        check("nop_valid", int'(bus.out_valid), 0);
        check("nop_hold", int'(bus.updated_pos), 8'h55);

        cmd(CLEAR, 8'h00, 8'h00, 4'd0);
        cmd(PUSH, 8'h21, 8'h07, 4'd0);
        cmd(MOVE, 8'h10, 8'h08, 4'd0);
        check("move1_pos", int'(bus.updated_pos), 8'h21);
        check("move1_dir", int'(bus.updated_dir), 8'h07);
        check("move1_count", int'(bus.count), 1);
        cmd(POP, 8'h00, 8'h00, 4'd0);
        check("pop1_pos", int'(bus.updated_pos), 8'h10);
        check("pop1_empty", int'(bus.empty), 1);
        cmd(MOVE, 8'h44, 8'h09, 4'd0);
        check("move_empty_valid", int'(bus.out_valid), 1);
        check("move_empty_pos", int'(bus.updated_pos), 8'h44);
        check("move_empty_count", int'(bus.count), 1);
        cmd(READ, 8'h00, 8'h00, 4'd0);
        check("move_empty_read", int'(bus.updated_pos), 8'h44);

        cmd(CLEAR, 8'h00, 8'h00, 4'd0);
        for (int i = 0; i < 5; i++) cmd(PUSH, 8'(8'hC0 + i), 8'hC0, 4'd0);
        check("pre_reset_count", int'(bus.count), 5);
        @(negedge clk);
        bus.op_en  = 1'b1;
        bus.mode   = PUSH;
        bus.wr_pos = 8'h99;
        bus.wr_dir = 8'h99;
        #2 reset = 1'b0;
        #1;
        check("async_rst_count", int'(bus.count), 0);
        check("async_rst_pos", int'(bus.updated_pos), 0);
        check("async_rst_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        check("rst_hold_count", int'(bus.count), 0);
        check("rst_hold_dir", int'(bus.updated_dir), 0);
        check("rst_hold_empty", int'(bus.empty), 1);
        @(negedge clk);
        bus.op_en = 1'b0;
        reset = 1'b1;
        cmd(PUSH, 8'h12, 8'h34, 4'd0);
        check("post_rst_count", int'(bus.count), 1);
        check("post_rst_pos", int'(bus.updated_pos), 8'h12);
        cmd(POP, 8'h00, 8'h00, 4'd0);
        check("post_rst_pop", int'(bus.updated_pos), 8'h12);
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    always @(negedge clk) begin
        if (bus.out_valid && bus.err) begin
            n_checks++;
            n_errors++;
            $display("FAIL valid_err_excl: out_valid=1 err=1 expected never both");
        end
        if (bus.full && bus.empty) begin
            n_checks++;
            n_errors++;
            $display("FAIL full_empty_excl: full=1 empty=1 expected never both");
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/segment_queue.md
SEGMENT_QUEUE -- requirements
Module: segment_queue

Interface
REQ-001 Parameter DEPTH, default 16: number of entries; SHALL be a power of two, >= 2.
REQ-002 Parameter POS_W, default 8: position field width.
REQ-003 Parameter DIR_W, default 8: direction field width.
REQ-004 Derived widths SHALL be AW = clog2(DEPTH) for index/pointers and CW = AW+1 for count.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 op_en  input  1  command strobe; mode is acted on only in cycles where op_en=1.
REQ-008 mode  input  3  command: 000 NOP, 001 PUSH, 010 POP, 011 MOVE, 100 READ, 101 WRITE, 110 CLEAR, 111 reserved.
REQ-009 wr_pos  input  POS_W  position data for PUSH/MOVE/WRITE.
REQ-010 wr_dir  input  DIR_W  direction data for PUSH/MOVE/WRITE.
REQ-011 address  input  AW  entry index for READ/WRITE; 0 = head (newest), count-1 = tail (oldest).
REQ-012 updated_pos  output  POS_W  registered result position.
REQ-013 updated_dir  output  DIR_W  registered result direction.
REQ-014 out_valid  output  1  one-cycle pulse: updated_pos/updated_dir carry a new result.
REQ-015 err  output  1  one-cycle pulse: command rejected.
REQ-016 full  output  1  count == DEPTH.
REQ-017 empty  output  1  count == 0.
REQ-018 count  output  CW  number of stored entries.

Function
REQ-019 Storage SHALL be a circular buffer of DEPTH {pos,dir} entries with head and tail pointers that wrap modulo DEPTH.
REQ-020 All outputs SHALL be registered; command issued in cycle N SHALL produce results (out_valid, err, data, count, flags) visible after edge N+1.
REQ-021 updated_pos/updated_dir SHALL hold their last value whenever out_valid=0.
REQ-022 PUSH, not full: write {wr_pos,wr_dir} as new head, count+1, out_valid=1 with the written entry.
REQ-023 POP, not empty: remove tail, count-1, out_valid=1 with the removed entry.
REQ-024 MOVE, not empty: push new head and drop tail in the same cycle, count unchanged, out_valid=1 with the dropped tail entry.
REQ-025 MOVE when empty SHALL behave as PUSH (count becomes 1, out_valid=1 with the new entry).
REQ-026 MOVE when full SHALL succeed (slot freed by tail is reused); count stays DEPTH.
REQ-027 MOVE with count==1 SHALL leave exactly the new entry stored; the old entry is output.
REQ-028 READ, address < count: out_valid=1 with entry at index address; no state change.
REQ-029 WRITE, address < count: overwrite entry at index address; out_valid=1 echoing the written entry; count unchanged.
REQ-030 CLEAR: count=0, head/tail to reset positions, out_valid=0, err=0; storage contents need not be zeroed.
REQ-031 Rejected commands (PUSH when full, POP when empty, READ/WRITE with address >= count, mode 111) SHALL assert err=1, out_valid=0, and change no state.
REQ-032 NOP or op_en=0 SHALL change no state and leave out_valid=0, err=0.
REQ-033 out_valid and err SHALL never both be 1.
REQ-034 full and empty SHALL be decoded from the registered count and never both be 1.

Reset
REQ-035 reset=0 SHALL immediately force count=0, empty=1, full=0, out_valid=0, err=0, updated_pos=0, updated_dir=0, head/tail pointers to 0.
REQ-036 Reset asserted mid-operation SHALL abort the command in flight; no partial update survives.
REQ-037 After reset deassertion, the first command SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-038 Reset, then POP -> err=1, out_valid=0, count=0, empty=1.
REQ-039 DEPTH=16: PUSH pos 0..15 -> full=1, count=16; 17th PUSH -> err=1, count stays 16; READ address 0 -> pos 15; READ address 15 -> pos 0.
REQ-040 Full buffer, MOVE with pos 0xAA -> out_valid=1 with pos 0 (tail), count=16; READ address 0 -> 0xAA; repeat 20 MOVEs -> pointers wrap, READ values match model.
REQ-041 count=3, READ address 3 -> err=1; WRITE address 1 pos 0x55/dir 0x02 -> echo, then READ address 1 -> 0x55/0x02.
REQ-042 count=1, MOVE pos 0x10 -> outputs old entry, count=1; POP -> outputs 0x10, empty=1; MOVE on empty -> count=1.
REQ-043 PUSH 5 entries, assert reset during a PUSH cycle -> count=0, all outputs 0; CLEAR on non-empty buffer -> count=0, err=0.
